// File: rtl/genome_pkg.sv
// Shared nucleotide definitions for the 2-bit genome datapath
// (unpacker, decoder, packer).
package genome_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;

    localparam int WORD_W_DEF = 32;

    // Bases carried by one packed word of width w.
    function automatic int bpw(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/base_unpacker.sv
// Serialises packed 2-bit base words into one base per clock with record-end marking.
// Optional record length counter enabled by defining UNPACK_CNT_EN.
module base_unpacker
    import genome_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    localparam int BPW = bpw(WORD_W),
    localparam int NW  = $clog2(BPW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [NW-1:0]     in_nbases,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_base,
    output logic              out_last
`ifdef UNPACK_CNT_EN
    ,
    output logic [31:0]       rec_len,
    output logic              rec_len_valid
`endif
);

    localparam int IW = $clog2(BPW);

    logic [WORD_W-1:0] hold_data;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     lim;
    logic              hold_last;
    logic              full;

    logic              at_end;
    logic              accept;
    logic              fire;
    logic [NW-1:0]     eff_n;
    logic [IW-1:0]     lim_next;

    assign at_end    = (idx == lim);
    assign in_ready  = !full || (out_ready && at_end);
    assign accept    = in_valid && in_ready;
    assign fire      = full && out_ready;

    assign out_valid = full;
    assign out_base  = hold_data[2*idx +: 2];
    assign out_last  = full && hold_last && at_end;

    // 0 and anything above BPW both mean a full word.
    always_comb begin
        eff_n = in_nbases;
        if (in_nbases == '0 || in_nbases > NW'(BPW))
            eff_n = NW'(BPW);
        lim_next = in_last ? IW'(eff_n - NW'(1)) : IW'(BPW - 1);
    end

    // A load takes priority: it also covers consuming the final base in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            idx       <= '0;
            lim       <= '0;
            hold_last <= 1'b0;
            full      <= 1'b0;
        end else if (accept) begin
            hold_data <= in_data;
            idx       <= '0;
            lim       <= lim_next;
            hold_last <= in_last;
            full      <= 1'b1;
        end else if (fire) begin
            if (!at_end)
                idx <= idx + IW'(1);
            else
                full <= 1'b0;
        end
    end

`ifdef UNPACK_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            rec_len       <= '0;
            rec_len_valid <= 1'b0;
        end else begin
            rec_len_valid <= 1'b0;
            if (fire) begin
                if (out_last) begin
                    rec_len       <= cnt + 32'd1;
                    rec_len_valid <= 1'b1;
                    cnt           <= '0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_base_unpacker.sv
// Scoreboard bench for base_unpacker: driver queues expected bases, negedge monitor checks them.
module tb_base_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [4:0]  in_nbases = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_base;
    logic        out_last;
`ifdef UNPACK_CNT_EN
    logic [31:0] rec_len;
    logic        rec_len_valid;
`endif

    base_unpacker #(.WORD_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbases(in_nbases),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_base(out_base), .out_last(out_last)
`ifdef UNPACK_CNT_EN
        , .rec_len(rec_len), .rec_len_valid(rec_len_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] b; logic l; } exp_t;
    exp_t sb[$];
    int   hs_cyc[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at negedge completes on the next posedge.
    logic       prev_stall = 1'b0;
    logic [1:0] prev_base;
    logic       prev_last;
    int         rec_cnt = 0;
    logic       pend = 1'b0;
    int         pend_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rec_cnt = 0;
            pend    = 1'b0;
        end else begin
`ifdef UNPACK_CNT_EN
            if (pend) begin
                chk("rec_len_valid", 32'(rec_len_valid), 32'd1);
                chk("rec_len", rec_len, 32'(pend_len));
            end else if (rec_len_valid) begin
                chk("rec_len_valid_spurious", 32'(rec_len_valid), 32'd0);
            end
`endif
            pend = 1'b0;
            if (prev_stall && out_valid)
                chk("stall_stable", {29'd0, out_base, out_last}, {29'd0, prev_base, prev_last});
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_base", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("base_last", {29'd0, out_base, out_last}, {29'd0, e.b, e.l});
                    rec_cnt++;
                    if (e.l) begin
                        pend     = 1'b1;
                        pend_len = rec_cnt;
                        rec_cnt  = 0;
                    end
                end
            end
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_base  = out_base;
        prev_last  = out_last;
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [4:0] nb,
                             input int npush, output int waits);
        int n;
        exp_t e;
        n = (!last || nb == 0 || nb > 16) ? 16 : int'(nb);
        for (int k = 0; k < n && (npush < 0 || k < npush); k++) begin
            e.b = d[2*k +: 2];
            e.l = last && (k == n - 1);
            sb.push_back(e);
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_nbases = nb;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 200) chk("accept_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("first_base_latency", {30'd0, out_valid, out_base}, {30'd0, 1'b1, d[1:0]});
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 300) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w;
        logic [3:0] pat;
        pat = 4'b1001;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_base", 32'(out_base), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
`ifdef UNPACK_CNT_EN
        chk("rst_rec_len", rec_len, 32'd0);
        chk("rst_rec_len_valid", 32'(rec_len_valid), 32'd0);
`endif

        // Short last word: 11,10,01 with out_last on the third.
        send_word(32'h0000_001B, 1'b1, 5'd3, -1, w);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("short_idle", 32'(out_valid), 32'd0);

        // Full word 00,01,10,11 then twelve 00.
        send_word(32'h0000_00E4, 1'b0, 5'd0, -1, w);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back full words, no gap, in_ready only on the 16th base.
        hs_cyc.delete();
        send_word(32'hFFFF_FFFF, 1'b0, 5'd0, -1, w);
        chk("b2b_w1_waits", 32'(w), 32'd0);
        send_word(32'h5555_5555, 1'b0, 5'd0, -1, w);
        chk("b2b_w2_waits", 32'(w), 32'd15);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_count", 32'(hs_cyc.size()), 32'd32);
        if (hs_cyc.size() == 32)
            chk("b2b_no_gap", 32'(hs_cyc[31] - hs_cyc[0]), 32'd31);

        // Stall pattern 1,0,0,1 on a last word.
        fork
            send_word(32'h9C3A_E127, 1'b1, 5'd0, -1, w);
            for (int i = 0; i < 48; i++) begin
                out_ready = pat[i % 4];
                @(posedge clk);
                #1;
            end
        join
        out_ready = 1'b1;
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        // Reset while base 7 is presented.
        send_word(32'hA5C3_7E19, 1'b0, 5'd0, 7, w);
        wait_drain();
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_last", 32'(out_last), 32'd0);
`ifdef UNPACK_CNT_EN
        chk("midrst_rec_len", rec_len, 32'd0);
`endif

        // in_nbases=0 on a last word: 16 bases, record length 16.
        send_word(32'h0123_4567, 1'b1, 5'd0, -1, w);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;

        // in_nbases above BPW clamps to a full word.
        send_word(32'hDEAD_BEEF, 1'b1, 5'd20, -1, w);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", 32'(out_valid), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/base_unpacker.md
# base_unpacker

Upstream feeder for the 2-bit-to-ASCII nucleotide decoder. Accepts packed genome words (WORD_W/2 two-bit base codes per word) over a valid/ready handshake and serialises them into one 2-bit base code per cycle for the decoder, with a record-end marker. It sustains one base per clock with no bubble between consecutive words. Base encoding is A=00, C=01, T=10, G=11.

## Interface
- WORD_W, 32: packed input word width; even, ≥4. BPW = WORD_W/2 bases per word.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  packed word offered
- in_ready  out  1  unpacker accepts word this cycle
- in_data  in  WORD_W  packed bases; base k in bits [2k+1:2k], base 0 emitted first
- in_last  in  1  word is the final word of a record
- in_nbases  in  $clog2(BPW+1)  valid bases in a last word, 1..BPW; 0 means BPW; ignored when in_last=0
- out_valid  out  1  base code valid
- out_ready  in  1  decoder accepts base
- out_base  out  2  base code
- out_last  out  1  out_base is final base of record
- rec_len  out  32  (UNPACK_CNT_EN only) base count of last completed record
- rec_len_valid  out  1  (UNPACK_CNT_EN only) one-cycle pulse when rec_len updates

## Operation
- State: holding register hold_data[WORD_W-1:0], index idx (0..BPW-1), end index lim, hold_last flag, full flag.
- Input handshake: word accepted when in_valid && in_ready. On accept: hold_data←in_data, idx←0, hold_last←in_last, lim←(in_last ? eff_nbases : BPW)−1, where eff_nbases = (in_nbases==0) ? BPW : in_nbases; full←1.
- out_valid = full; out_base = hold_data[2·idx+1:2·idx]; out_last = full && hold_last && idx==lim.
- Output handshake (out_valid && out_ready): if idx<lim, idx←idx+1; else word consumed (full←0 unless a new word is accepted in the same cycle).
- in_ready = !full || (out_ready && idx==lim). Simultaneous consume of final base and accept of new word loads the new word; no idle cycle.
- Outputs hold stable while out_valid && !out_ready.
- in_nbases > BPW: clamp to BPW.

## Timing
- Reset values: out_valid=0, out_base=00, out_last=0, in_ready=1 in the cycle after reset deasserts (combinational from full=0), idx=0, full=0; rec_len=0, rec_len_valid=0.
- Latency: word accepted at edge N → base 0 on out_base in cycle N+1.
- Throughput: one base per cycle with out_ready held high; a BPW-base word occupies exactly BPW cycles.
- Reset mid-word: all held bases discarded, no out_last emitted, count cleared.
- in_ready is combinational from out_ready; out_* are registered state only.

## Configuration
- UNPACK_CNT_EN defined: 32-bit counter increments on each output handshake; on the handshake where out_last=1, rec_len←count+1, rec_len_valid pulses for one cycle, counter←0. Counter wraps at 2^32 silently.
- Undefined: rec_len/rec_len_valid ports and counter absent; streaming behaviour identical.

## Structure
- Package genome_pkg: BASE_A=2'b00, BASE_C=2'b01, BASE_T=2'b10, BASE_G=2'b11, WORD_W default, BPW derivation function. Shared with the decoder and future packer.
- Single module; no sub-module required. Record counter is inline logic under UNPACK_CNT_EN.

## Test plan
- WORD_W=32, in_data=0x0000_00E4, in_last=0, out_ready=1 → out_base sequence 00,01,10,11 then twelve 00; out_last=0 throughout; 16 cycles.
- Two back-to-back words 0xFFFF_FFFF then 0x5555_5555, in_valid and out_ready held high → 16×11 then 16×01 with no gap; in_ready high only on the cycle of the 16th base.
- in_data=0x0000_001B, in_last=1, in_nbases=3 → bases 11,10,01; out_last=1 on 3rd; with UNPACK_CNT_EN rec_len=3, rec_len_valid pulses once the cycle after.
- out_ready toggled 1,0,0,1 during a word → out_base/out_last stable while stalled; no base dropped or duplicated.
- rst asserted on base 7 of a word → next cycle out_valid=0, in_ready=1; next word starts from its base 0; rec_len unchanged at 0.
- in_last=1, in_nbases=0 → all 16 bases emitted, out_last on the 16th; rec_len=16.
